// File: rtl/barrel_distortion_corrector.sv
// Frame-buffered radial (barrel) lens distortion corrector, AXI4-Stream in/out, one pixel per beat.
// Optional build macro BDC_EDGE_CLAMP_EN: clamp out-of-frame sources to the border instead of black fill.
module barrel_distortion_corrector #(
  parameter int          WIDTH         = 1280,
  parameter int          HEIGHT        = 720,
  parameter int          DATA_WIDTH    = 24,
  parameter logic [15:0] DISTORTION_K1 = 16'h0100,
  parameter logic [15:0] DISTORTION_K2 = 16'h0020
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  input  logic                  m_axis_tready
);

  localparam int unsigned NPIX = WIDTH * HEIGHT;
  localparam int unsigned AW   = $clog2(NPIX);
  localparam int unsigned XW   = $clog2(WIDTH);
  localparam int unsigned YW   = $clog2(HEIGHT);
  localparam int unsigned CX   = WIDTH / 2;
  localparam int unsigned CY   = HEIGHT / 2;
  localparam int unsigned DW   = ((XW > YW) ? XW : YW) + 1;
  localparam int unsigned R2W  = 2 * DW + 1;
  localparam int unsigned RB   = $clog2(CX * CX + CY * CY);
  localparam int unsigned RNW  = 17;
  localparam int unsigned KPW  = 16 + RNW;
  localparam int unsigned TW   = KPW - 8;
  localparam int unsigned SW   = 27;
  localparam int unsigned PW   = DW + SW + 1;

  localparam logic signed [PW-1:0] CX_S = PW'(CX);
  localparam logic signed [PW-1:0] CY_S = PW'(CY);
  localparam logic signed [PW-1:0] W_S  = PW'(WIDTH);
  localparam logic signed [PW-1:0] H_S  = PW'(HEIGHT);

  typedef enum logic [0:0] {ST_CAPTURE, ST_RENDER} state_t;

  state_t          state, state_d;
  logic [AW-1:0]   wr_addr;
  logic [AW-1:0]   wa_c;
  logic            wr_en_c;
  logic            adv_c;
  logic            issue_c;

  logic [XW-1:0]   x_cnt;
  logic [YW-1:0]   y_cnt;
  logic            gen_done;

  logic                   v1, sof1, eof1;
  logic signed [DW-1:0]   dx1, dy1;
  logic                   v2, sof2, eof2;
  logic signed [DW-1:0]   dx2, dy2;
  logic [RNW-1:0]         rn2_2;
  logic                   v3, sof3, eof3;
  logic signed [DW-1:0]   dx3, dy3;
  logic [RNW-1:0]         rn4_3;
  logic [TW-1:0]          t1_3;
  logic                   v4, sof4, eof4;
  logic signed [DW-1:0]   dx4, dy4;
  logic [SW-1:0]          s4;
  logic                   v5, sof5, eof5, ok5;
  logic [DATA_WIDTH-1:0]  ram_q;

  logic signed [R2W-1:0]  dxq_c, dyq_c;
  logic [R2W-1:0]         r2_c;
  logic [R2W+15:0]        r2_sh_c;
  logic [RNW-1:0]         rn2_c;
  logic [2*RNW-1:0]       sq_c;
  logic [RNW-1:0]         rn4_c;
  logic [KPW-1:0]         k1p_c, k2p_c;
  logic [TW-1:0]          t1_c;
  logic [SW-1:0]          s_c;
  logic signed [PW-1:0]   dxe_c, dye_c, se_c, px_c, py_c, xs_c, ys_c;
  logic [XW-1:0]          xs_sel_c;
  logic [YW-1:0]          ys_sel_c;
  logic                   ok_c;
  logic [AW-1:0]          rd_addr_c;

  logic [DATA_WIDTH-1:0]  mem [NPIX];

  assign adv_c   = !m_axis_tvalid || m_axis_tready;
  assign issue_c = (state == ST_RENDER) && adv_c && !gen_done;

  // Capture/render sequencing; a SOF beat always lands at address 0.
  always_comb begin
    state_d = state;
    wr_en_c = 1'b0;
    wa_c    = wr_addr;
    case (state)
      ST_CAPTURE: begin
        if (s_axis_tvalid && s_axis_tready) begin
          wr_en_c = 1'b1;
          wa_c    = s_axis_tuser ? '0 : wr_addr;
          if (s_axis_tlast || (wa_c == AW'(NPIX - 1))) state_d = ST_RENDER;
        end
      end
      ST_RENDER: begin
        if (m_axis_tvalid && m_axis_tready && m_axis_tlast) state_d = ST_CAPTURE;
      end
      default: state_d = ST_CAPTURE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_CAPTURE;
      wr_addr       <= '0;
      s_axis_tready <= 1'b1;
    end else begin
      state         <= state_d;
      s_axis_tready <= (state_d == ST_CAPTURE);
      if (state_d != ST_CAPTURE) wr_addr <= '0;
      else if (wr_en_c)          wr_addr <= wa_c + 1'b1;
    end
  end

  // Raster-order output coordinate generator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_cnt    <= '0;
      y_cnt    <= '0;
      gen_done <= 1'b0;
    end else if (state == ST_CAPTURE) begin
      x_cnt    <= '0;
      y_cnt    <= '0;
      gen_done <= 1'b0;
    end else if (issue_c) begin
      if (x_cnt == XW'(WIDTH - 1)) begin
        x_cnt <= '0;
        if (y_cnt == YW'(HEIGHT - 1)) gen_done <= 1'b1;
        else                          y_cnt    <= y_cnt + 1'b1;
      end else begin
        x_cnt <= x_cnt + 1'b1;
      end
    end
  end

  // Radial scale: rn2 normalised to Q0.16, s = 1 + k1*rn2 + k2*rn4 in Q2.16.
  always_comb begin
    dxq_c   = R2W'(dx1);
    dyq_c   = R2W'(dy1);
    r2_c    = dxq_c * dxq_c + dyq_c * dyq_c;
    r2_sh_c = {r2_c, 16'd0} >> RB;
    rn2_c   = RNW'(r2_sh_c);
    sq_c    = (2*RNW)'(rn2_2) * (2*RNW)'(rn2_2);
    rn4_c   = RNW'(sq_c >> 16);
    k1p_c   = KPW'(DISTORTION_K1) * KPW'(rn2_2);
    t1_c    = TW'(k1p_c >> 8);
    k2p_c   = KPW'(DISTORTION_K2) * KPW'(rn4_3);
    s_c     = SW'(32'd65536) + SW'(t1_3) + SW'(k2p_c >> 8);
  end

  // Source coordinate, range check and RAM read address.
  always_comb begin
    dxe_c    = PW'(dx4);
    dye_c    = PW'(dy4);
    se_c     = PW'(s4);
    px_c     = dxe_c * se_c;
    py_c     = dye_c * se_c;
    xs_c     = CX_S + (px_c >>> 16);
    ys_c     = CY_S + (py_c >>> 16);
    xs_sel_c = '0;
    ys_sel_c = '0;
`ifdef BDC_EDGE_CLAMP_EN
    ok_c = 1'b1;
    if (xs_c[PW-1])        xs_sel_c = '0;
    else if (xs_c >= W_S)  xs_sel_c = XW'(WIDTH - 1);
    else                   xs_sel_c = XW'(xs_c);
    if (ys_c[PW-1])        ys_sel_c = '0;
    else if (ys_c >= H_S)  ys_sel_c = YW'(HEIGHT - 1);
    else                   ys_sel_c = YW'(ys_c);
`else
    ok_c = !xs_c[PW-1] && (xs_c < W_S) && !ys_c[PW-1] && (ys_c < H_S);
    if (ok_c) begin
      xs_sel_c = XW'(xs_c);
      ys_sel_c = YW'(ys_c);
    end
`endif
    rd_addr_c = AW'(ys_sel_c) * AW'(WIDTH) + AW'(xs_sel_c);
  end

  // Frame buffer; the read register is pipeline stage 5 and obeys backpressure.
  always_ff @(posedge clk) begin
    if (wr_en_c) mem[wa_c] <= s_axis_tdata;
    if (adv_c)   ram_q     <= mem[rd_addr_c];
  end

  // Six-stage remap pipeline, all stages advance together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0; sof1 <= 1'b0; eof1 <= 1'b0; dx1 <= '0; dy1 <= '0;
      v2 <= 1'b0; sof2 <= 1'b0; eof2 <= 1'b0; dx2 <= '0; dy2 <= '0; rn2_2 <= '0;
      v3 <= 1'b0; sof3 <= 1'b0; eof3 <= 1'b0; dx3 <= '0; dy3 <= '0; rn4_3 <= '0; t1_3 <= '0;
      v4 <= 1'b0; sof4 <= 1'b0; eof4 <= 1'b0; dx4 <= '0; dy4 <= '0; s4 <= '0;
      v5 <= 1'b0; sof5 <= 1'b0; eof5 <= 1'b0; ok5 <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else if (adv_c) begin
      v1   <= issue_c;
      sof1 <= issue_c && (x_cnt == '0) && (y_cnt == '0);
      eof1 <= issue_c && (x_cnt == XW'(WIDTH - 1)) && (y_cnt == YW'(HEIGHT - 1));
      dx1  <= DW'(x_cnt) - DW'(CX);
      dy1  <= DW'(y_cnt) - DW'(CY);

      v2 <= v1; sof2 <= sof1; eof2 <= eof1; dx2 <= dx1; dy2 <= dy1; rn2_2 <= rn2_c;
      v3 <= v2; sof3 <= sof2; eof3 <= eof2; dx3 <= dx2; dy3 <= dy2; rn4_3 <= rn4_c; t1_3 <= t1_c;
      v4 <= v3; sof4 <= sof3; eof4 <= eof3; dx4 <= dx3; dy4 <= dy3; s4 <= s_c;
      v5 <= v4; sof5 <= sof4; eof5 <= eof4; ok5 <= ok_c;

      m_axis_tvalid <= v5;
      m_axis_tdata  <= (v5 && ok5) ? ram_q : '0;
      m_axis_tuser  <= v5 && sof5;
      m_axis_tlast  <= v5 && eof5;
    end
  end

endmodule

// File: tb/tb_barrel_distortion_corrector.sv
// Directed bench: identity, k1-only and default-coefficient instances on a shared 16x8 input stream.
module tb_barrel_distortion_corrector;

  localparam int W  = 16;
  localparam int H  = 8;
  localparam int N  = W * H;
  localparam int DW = 24;

  logic          clk;
  logic          rst;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid, s_tlast, s_tuser;
  logic          m_tready;

  logic          rdy_id, v_id, l_id, u_id;
  logic [DW-1:0] d_id;
  logic          rdy_k1, v_k1, l_k1, u_k1;
  logic [DW-1:0] d_k1;
  logic          rdy_df, v_df, l_df, u_df;
  logic [DW-1:0] d_df;

  barrel_distortion_corrector #(.WIDTH(W), .HEIGHT(H), .DATA_WIDTH(DW),
    .DISTORTION_K1(16'h0000), .DISTORTION_K2(16'h0000)) u_id_dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
    .s_axis_tuser(s_tuser), .s_axis_tready(rdy_id),
    .m_axis_tdata(d_id), .m_axis_tvalid(v_id), .m_axis_tlast(l_id),
    .m_axis_tuser(u_id), .m_axis_tready(m_tready));

  barrel_distortion_corrector #(.WIDTH(W), .HEIGHT(H), .DATA_WIDTH(DW),
    .DISTORTION_K1(16'h0100), .DISTORTION_K2(16'h0000)) u_k1_dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
    .s_axis_tuser(s_tuser), .s_axis_tready(rdy_k1),
    .m_axis_tdata(d_k1), .m_axis_tvalid(v_k1), .m_axis_tlast(l_k1),
    .m_axis_tuser(u_k1), .m_axis_tready(m_tready));

  barrel_distortion_corrector #(.WIDTH(W), .HEIGHT(H), .DATA_WIDTH(DW)) u_df_dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
    .s_axis_tuser(s_tuser), .s_axis_tready(rdy_df),
    .m_axis_tdata(d_df), .m_axis_tvalid(v_df), .m_axis_tlast(l_df),
    .m_axis_tuser(u_df), .m_axis_tready(m_tready));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int kind, input int n);
    int x, y;
    x = n % W;
    y = n / W;
    case (kind)
      0:       return DW'(n);
      1:       return 24'hA00000 | DW'(n);
      2:       return 24'h550000 | DW'(n);
      3:       return 24'h330000 | DW'(n);
      default: return ((((x >> 3) ^ (y >> 3)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
    endcase
  endfunction

  // Output collector for accepted beats, plus stall-hold and s_tready turnaround checks.
  logic [DW-1:0] o_id [N];
  logic [DW-1:0] o_k1 [N];
  logic [DW-1:0] o_df [N];
  logic          ou   [N];
  logic          ol   [N];
  int            ocnt  = 0;
  int            fbase = 0;
  logic          hold_p = 1'b0;
  logic [26:0]   hold_v = '0;
  logic          rdy_pend = 1'b0;
  logic          toggle_en = 1'b0;

  always @(negedge clk) begin
    int idx;
    if (rst) begin
      hold_p   = 1'b0;
      rdy_pend = 1'b0;
    end else begin
      if (rdy_pend) begin
        check("s_tready_after_last", 32'(rdy_id), 32'd1);
        rdy_pend = 1'b0;
      end
      if (hold_p) check("stall_hold", 32'({v_id, u_id, l_id, d_id}), 32'(hold_v));
      hold_p = v_id && !m_tready;
      hold_v = {1'b1, u_id, l_id, d_id};
      if (v_id && m_tready) begin
        idx = ocnt - fbase;
        if (idx >= 0 && idx < N) begin
          o_id[idx] = d_id;
          o_k1[idx] = d_k1;
          o_df[idx] = d_df;
          ou[idx]   = u_id;
          ol[idx]   = l_id;
        end
        ocnt++;
        if (l_id) begin
          check("s_tready_at_last", 32'(rdy_id), 32'd0);
          rdy_pend = 1'b1;
        end
      end
    end
  end

  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_tready = toggle_en ? ~m_tready : 1'b1;
    end
  end

  task automatic send_beat(input logic [DW-1:0] d, input logic sof, input logic eof);
    int waitc;
    waitc    = 0;
    s_tdata  = d;
    s_tvalid = 1'b1;
    s_tuser  = sof;
    s_tlast  = eof;
    while (!rdy_id && waitc < 1000) begin
      @(posedge clk);
      #1;
      waitc++;
    end
    if (!rdy_id) check("send_ready_timeout", 32'(rdy_id), 32'd1);
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tuser  = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic send_frame(input int kind);
    for (int n = 0; n < N; n++) send_beat(pat(kind, n), n == 0, n == N - 1);
  endtask

  task automatic wait_frame();
    int c;
    c = 0;
    while ((ocnt - fbase) < N && c < 5000) begin
      @(posedge clk);
      #1;
      c++;
    end
    repeat (20) @(posedge clk);
    #1;
    check("beats_per_frame", 32'(ocnt - fbase), 32'(N));
  endtask

  initial begin
    int lat, nu, nl, nz, c;
    s_tdata  = '0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
    rst      = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_s_tready", 32'(rdy_id), 32'd1);
    check("reset_m_tvalid", 32'(v_id), 32'd0);
    check("reset_m_tdata", 32'(d_id), 32'd0);
    check("reset_m_tlast", 32'(l_id), 32'd0);
    check("reset_m_tuser", 32'(u_id), 32'd0);
    check("reset_s_tready_df", 32'(rdy_df), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Frame A: in[n]=n, no backpressure.
    fbase = ocnt;
    send_frame(0);
    check("s_tready_render", 32'(rdy_id), 32'd0);
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      if (v_id) begin
        lat = i;
        break;
      end
    end
    check("first_valid_within_6", 32'(lat >= 1 && lat <= 6), 32'd1);
    wait_frame();
    nu = 0;
    nl = 0;
    for (int n = 0; n < N; n++) begin
      check($sformatf("identity[%0d]", n), 32'(o_id[n]), 32'(n));
      nu += int'(ou[n]);
      nl += int'(ol[n]);
    end
    check("tuser_beat0", 32'(ou[0]), 32'd1);
    check("tuser_count", 32'(nu), 32'd1);
    check("tlast_beat127", 32'(ol[N-1]), 32'd1);
    check("tlast_count", 32'(nl), 32'd1);
    check("k1_centre_a", 32'(o_k1[72]), 32'd72);

    // Frame B: tagged pixels under 1/0 m_tready toggling.
    toggle_en = 1'b1;
    fbase = ocnt;
    send_frame(1);
    wait_frame();
    toggle_en = 1'b0;
    for (int n = 0; n < N; n++)
      check($sformatf("toggle_identity[%0d]", n), 32'(o_id[n]), 32'(24'hA00000 | 24'(n)));
    check("k1_centre_b", 32'(o_k1[72]), 32'h00A00048);
`ifdef BDC_EDGE_CLAMP_EN
    check("k1_corner_clamp", 32'(o_k1[0]), 32'h00A00000);
`else
    check("k1_corner_black", 32'(o_k1[0]), 32'h00000000);
`endif

    // Frame C: SOF re-sent after 40 beats; only the second frame must appear.
    fbase = ocnt;
    for (int n = 0; n < 40; n++) send_beat(pat(2, n), n == 0, 1'b0);
    send_frame(3);
    wait_frame();
    for (int n = 0; n < N; n++)
      check($sformatf("restart_identity[%0d]", n), 32'(o_id[n]), 32'(24'h330000 | 24'(n)));

    // Frame D: 8x8-square checkerboard through default coefficients.
    fbase = ocnt;
    send_frame(4);
    wait_frame();
    nz = 0;
    for (int n = 0; n < N; n++) if (o_df[n] != '0) nz++;
    check("checker_nonzero_gt_quarter", 32'(nz > N / 4), 32'd1);
    check("checker_centre", 32'(o_df[72]), 32'h00FFFFFF);

    // Reset during render aborts output immediately.
    fbase = ocnt;
    send_frame(0);
    c = 0;
    while (!v_id && c < 50) begin
      @(posedge clk);
      #1;
      c++;
    end
    check("render_started", 32'(v_id), 32'd1);
    rst = 1'b1;
    #1;
    check("reset_abort_tvalid", 32'(v_id), 32'd0);
    check("reset_abort_tready", 32'(rdy_id), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
